pipe_shifter: RTL and testbench
===============================

Name: pipe_shifter

Overview:
- Parametrised, fully pipelined barrel shifter for the datapath; successor to the combinational shifter.
- Performs logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand.
- Uses one registered mux level per shift-amount bit, with a valid/ready handshake, global-stall backpressure, and carry/zero flags for the ALU condition codes.
- Throughput: one operation per cycle.

Parameters:
- WIDTH, 16, operand width; power of two, at least 4.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, never overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  an input operation is presented.
- in_ready  output  1  the block accepts an input this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  a result is presented.
- out_ready  input  1  the consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted or rotated out.
- out_zero  output  1  high when out_data == 0.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears every stage valid bit, data, amount, op and flag register to 0.
  - out_valid=0, out_data=0, out_carry=0, out_zero=0.
  - in_ready=1 as soon as reset is released.
  - Reset asserted mid-operation discards all in-flight operations; nothing emerges afterwards.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - An input is accepted only when in_valid & in_ready.
  - When stall=1, every pipeline register holds its value and out_data, out_carry and out_zero stay stable.
  - When stall=0, all stages advance together; bubbles (valid=0) advance like data.
  - Bubbles are not collapsed.
- Pipeline: stages k = 0..SHW-1.
  - Stage k applies a 2^k shift/rotate of the current op when amt[k]=1, otherwise passes the value through.
  - Stage k registers its result, valid, op and carry.
  - Stage 0 registers the accepted input; stage SHW-1 drives the outputs.
  - Latency: a result appears on out_data exactly SHW cycles after acceptance, with no stalls (4 for WIDTH=16).
- Operation semantics (result truncated to WIDTH):
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with in_data[WIDTH-1].
  - ROR: bits leaving the LSB re-enter at the MSB.
- Carry:
  - Computed at acceptance from the original operand and carried down the pipe.
  - amt=0: carry=0 for all ops.
  - SLL: in_data[WIDTH-amt].
  - SRL, SRA, ROR: in_data[amt-1].
- Zero flag: out_zero = (out_data == 0), registered alongside out_data; 0 while out_valid=0.
- Ordering: results leave in acceptance order; none dropped or duplicated under any out_ready pattern.
- Full pipe: SHW operations in flight. With out_ready held 0, the pipe stays full, in_ready=0, and no input is consumed.
- Simultaneous accept and emit with stall=0: both occur in the same cycle.
- Values at the outputs while out_valid=0 are don't-care for consumers. The bench checks them only after reset, where they must be 0.

Test Plan:
- Reset, then WIDTH=16, in_data=F0F0, amt=4, one op per cycle through SLL/SRL/SRA/ROR, out_ready=1:
  - Results 0F00/c1, 0F0F/c0, FF0F/c0, 0F0F/c0.
  - Each appears 4 cycles after acceptance, on consecutive cycles.
- Edge amounts:
  - SRA F0F0 by 15 -> FFFF, carry 1.
  - SLL F0F0 by 0 -> F0F0, carry 0, zero 0.
  - SRL 0001 by 1 -> 0000, carry 1, zero 1.
  - ROR 8001 by 1 -> C000, carry 1.
- Backpressure:
  - Stream ops 1..6 (SLL 0001 by 0..5); drop out_ready for 3 cycles once out_valid=1.
  - in_ready=0 and out_data held during the stall.
  - After release, outputs are 0001, 0002, 0004, 0008, 0010, 0020 in order, none lost or repeated.
- Bubbles: in_valid toggles every other cycle -> out_valid pattern identical, delayed by 4 cycles.
- Reset mid-stream with 3 ops in flight -> outputs 0 immediately; out_valid stays 0 until new ops are accepted 4 cycles later.
- Exhaustive sweep of all op and amt combinations on random operands, compared against a reference model, including carry and zero.

Source files
------------

// File: rtl/pipe_shifter_if.sv
// Operation/result handshake bundle for pipe_shifter.
// The slave side is the shifter; the master side is its producer/consumer.
interface pipe_shifter_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );
endinterface

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: stage k applies a 2^k shift/rotate when amt[k] is set.
// A single global stall freezes every stage while the output is held.
module pipe_shifter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    pipe_shifter_if.slave io_bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic             r_valid [SHW];
    logic [WIDTH-1:0] r_data  [SHW];
    logic [SHW-1:0]   r_amt   [SHW];
    logic [1:0]       r_op    [SHW];
    logic             r_carry [SHW];
    logic             r_zero;

    logic             w_src_valid [SHW];
    logic [WIDTH-1:0] w_src_data  [SHW];
    logic [SHW-1:0]   w_src_amt   [SHW];
    logic [1:0]       w_src_op    [SHW];
    logic             w_src_carry [SHW];
    logic [WIDTH-1:0] w_nxt_data  [SHW];

    logic             w_stall;
    logic             w_carry_in;
    logic             w_zero_nxt;
    logic [SHW-1:0]   w_sll_idx;
    logic [SHW-1:0]   w_sr_idx;

    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       op,
                                                 input int unsigned      sh);
        case (op)
            OP_SLL:  f_shift = d << sh;
            OP_SRL:  f_shift = d >> sh;
            OP_SRA:  f_shift = $unsigned($signed(d) >>> sh);
            default: f_shift = (d >> sh) | (d << (WIDTH - sh));
        endcase
    endfunction

    assign w_stall = r_valid[SHW-1] & ~io_bus.out_ready;

    // WIDTH is a power of two, so WIDTH-amt wraps to 0 - amt in SHW bits.
    assign w_sll_idx = SHW'(0) - io_bus.in_amt;
    assign w_sr_idx  = io_bus.in_amt - SHW'(1);

    always_comb begin
        w_carry_in = 1'b0;
        if (io_bus.in_amt != '0) begin
            w_carry_in = (io_bus.in_op == OP_SLL) ? io_bus.in_data[w_sll_idx]
                                                  : io_bus.in_data[w_sr_idx];
        end
    end

    always_comb begin
        w_src_valid[0] = io_bus.in_valid & ~w_stall;
        w_src_data[0]  = io_bus.in_data;
        w_src_amt[0]   = io_bus.in_amt;
        w_src_op[0]    = io_bus.in_op;
        w_src_carry[0] = w_carry_in;
        for (int k = 1; k < SHW; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_data[k]  = r_data[k-1];
            w_src_amt[k]   = r_amt[k-1];
            w_src_op[k]    = r_op[k-1];
            w_src_carry[k] = r_carry[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            w_nxt_data[k] = w_src_amt[k][k] ? f_shift(w_src_data[k], w_src_op[k], 1 << k)
                                            : w_src_data[k];
        end
        w_zero_nxt = w_src_valid[SHW-1] & (w_nxt_data[SHW-1] == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_amt[k]   <= '0;
                r_op[k]    <= '0;
                r_carry[k] <= 1'b0;
            end
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= w_src_valid[k];
                r_data[k]  <= w_nxt_data[k];
                r_amt[k]   <= w_src_amt[k];
                r_op[k]    <= w_src_op[k];
                r_carry[k] <= w_src_carry[k];
            end
            r_zero <= w_zero_nxt;
        end
    end

    assign io_bus.in_ready  = ~w_stall;
    assign io_bus.out_valid = r_valid[SHW-1];
    assign io_bus.out_data  = r_data[SHW-1];
    assign io_bus.out_carry = r_carry[SHW-1];
    assign io_bus.out_zero  = r_zero;
endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter (WIDTH=16) with a behavioural shift model.
module tb_pipe_shifter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pipe_shifter_if #(.WIDTH(W)) bus ();

    pipe_shifter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Returns {zero, carry, result}, built from wide-word shifts of the operand.
    function automatic logic [17:0] model(input logic [15:0] d, input logic [1:0] op,
                                          input logic [3:0] amt);
        logic [31:0] w;
        logic [15:0] r;
        logic        c;
        case (op)
            2'b00: begin w = {16'h0, d} << amt; r = w[15:0]; c = w[16]; end
            2'b01: begin w = {d, 16'h0} >> amt; r = w[31:16]; c = w[15]; end
            2'b10: begin
                w = $unsigned($signed({d, 16'h0}) >>> amt);
                r = w[31:16];
                c = w[15];
            end
            default: begin w = {d, d} >> amt; r = w[15:0]; c = r[15]; end
        endcase
        if (amt == 4'd0) c = 1'b0;
        return {r == 16'h0, c, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_amt   = '0;
        bus.in_op    = '0;
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] a, input logic [1:0] o);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_op    = o;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.out_ready = 1'b0;
        step();
        #1;
        checks++;
        if ({bus.out_valid, bus.out_carry, bus.out_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got v%b c%b z%b want 000",
                     bus.out_valid, bus.out_carry, bus.out_zero);
        end
        checks++;
        if (bus.out_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0000", bus.out_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_directed_vectors();
        logic [15:0] vd [8];
        logic [3:0]  va [8];
        logic [1:0]  vo [8];
        logic [17:0] ve [8];
        int nout;
        vd = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0001, 16'h8001};
        va = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd15, 4'd0, 4'd1, 4'd1};
        vo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        ve = '{{2'b01, 16'h0F00}, {2'b00, 16'h0F0F}, {2'b00, 16'hFF0F}, {2'b00, 16'h0F0F},
               {2'b01, 16'hFFFF}, {2'b00, 16'hF0F0}, {2'b11, 16'h0000}, {2'b01, 16'hC000}};
        nout = 0;
        bus.out_ready = 1'b1;
        for (int it = 0; it < 16; it++) begin
            step();
            if (it < 8) drive(vd[it], va[it], vo[it]);
            else idle_inputs();
            #1;
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (nout >= 8) begin
                    errors++;
                    $display("FAIL directed_extra got %h want no result", bus.out_data);
                end else if ({bus.out_zero, bus.out_carry, bus.out_data} !== ve[nout]
                             || it != nout + 4) begin
                    errors++;
                    $display("FAIL directed[%0d] got z%b c%b %h at iter %0d want %h at iter %0d",
                             nout, bus.out_zero, bus.out_carry, bus.out_data, it, ve[nout],
                             nout + 4);
                end
                nout++;
            end
        end
        checks++;
        if (nout != 8) begin
            errors++;
            $display("FAIL directed_count got %0d want 8", nout);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_q [$];
        logic [15:0] want;
        int   sent;
        int   got;
        int   stalls;
        logic stall_on;
        sent = 0;
        got = 0;
        stalls = 0;
        for (int it = 0; it < 60 && got < 6; it++) begin
            step();
            stall_on = (bus.out_valid === 1'b1) && (stalls < 3);
            bus.out_ready = !stall_on;
            if (sent < 6) drive(16'h0001, 4'(sent), 2'b00);
            else idle_inputs();
            #1;
            checks++;
            if (bus.in_ready !== !stall_on) begin
                errors++;
                $display("FAIL bp_in_ready got %b want %b", bus.in_ready, !stall_on);
            end
            if (stall_on) begin
                checks++;
                if (exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_hold got %h want %h", bus.out_data,
                             (exp_q.size() == 0) ? 16'hxxxx : exp_q[0]);
                end
                stalls++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                exp_q.push_back(16'h0001 << sent);
                sent++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                if (bus.out_data !== want) begin
                    errors++;
                    $display("FAIL bp_order[%0d] got %h want %h", got, bus.out_data, want);
                end
                got++;
            end
        end
        checks++;
        if (got != 6 || stalls != 3) begin
            errors++;
            $display("FAIL bp_count got %0d results %0d stalls want 6 results 3 stalls",
                     got, stalls);
        end
    endtask

    task automatic test_bubbles();
        logic [17:0] exp_q [$];
        logic [17:0] want;
        logic        acc_hist [24];
        logic        exp_v;
        logic [15:0] d;
        logic [3:0]  a;
        logic [1:0]  o;
        bus.out_ready = 1'b1;
        for (int it = 0; it < 24; it++) begin
            step();
            if (it < 16 && (it % 2) == 0) begin
                d = 16'($urandom);
                a = 4'($urandom_range(0, 15));
                o = 2'($urandom_range(0, 3));
                drive(d, a, o);
            end else begin
                idle_inputs();
            end
            #1;
            acc_hist[it] = bus.in_valid;
            if (acc_hist[it]) exp_q.push_back(model(d, o, a));
            exp_v = (it >= 4) ? acc_hist[it-4] : 1'b0;
            checks++;
            if (bus.out_valid !== exp_v) begin
                errors++;
                $display("FAIL bubble_valid iter %0d got %b want %b", it, bus.out_valid, exp_v);
            end
            if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if ({bus.out_zero, bus.out_carry, bus.out_data} !== want) begin
                    errors++;
                    $display("FAIL bubble_data got z%b c%b %h want %h",
                             bus.out_zero, bus.out_carry, bus.out_data, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0] d;
        logic [17:0] want;
        bus.out_ready = 1'b1;
        for (int it = 0; it < 3; it++) begin
            step();
            drive(16'($urandom) | 16'h0100, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        step();
        idle_inputs();
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_carry, bus.out_zero, bus.out_data} !== 19'h0) begin
            errors++;
            $display("FAIL midreset_outputs got v%b c%b z%b %h want all 0",
                     bus.out_valid, bus.out_carry, bus.out_zero, bus.out_data);
        end
        step();
        reset = 1'b0;
        for (int it = 0; it < 8; it++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_ghost iter %0d got valid %b want 0", it, bus.out_valid);
            end
        end
        d = 16'h1234;
        want = model(d, 2'b11, 4'd4);
        for (int it = 0; it < 6; it++) begin
            step();
            if (it == 0) drive(d, 4'd4, 2'b11);
            else idle_inputs();
            #1;
            checks++;
            if (bus.out_valid !== (it == 4)) begin
                errors++;
                $display("FAIL midreset_new_valid iter %0d got %b want %b",
                         it, bus.out_valid, it == 4);
            end
            if (it == 4) begin
                checks++;
                if ({bus.out_zero, bus.out_carry, bus.out_data} !== want) begin
                    errors++;
                    $display("FAIL midreset_new_data got z%b c%b %h want %h",
                             bus.out_zero, bus.out_carry, bus.out_data, want);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [17:0] exp_q [$];
        logic [17:0] want;
        logic [15:0] d;
        logic        exp_rdy;
        int sent;
        int got;
        int it;
        sent = 0;
        got = 0;
        it = 0;
        while (got < 64 && it < 4000) begin
            step();
            it++;
            d = 16'($urandom);
            if (sent < 64 && $urandom_range(0, 3) != 0) drive(d, 4'(sent % 16), 2'(sent / 16));
            else idle_inputs();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !(bus.out_valid === 1'b1 && bus.out_ready === 1'b0);
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sweep_in_ready got %b want %b", bus.in_ready, exp_rdy);
            end
            if (bus.out_valid === 1'b0) begin
                checks++;
                if (bus.out_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_zero_idle got %b want 0", bus.out_zero);
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                exp_q.push_back(model(d, 2'(sent / 16), 4'(sent % 16)));
                sent++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 18'hxxxxx;
                checks++;
                if ({bus.out_zero, bus.out_carry, bus.out_data} !== want) begin
                    errors++;
                    $display("FAIL sweep[%0d] got z%b c%b %h want %h", got,
                             bus.out_zero, bus.out_carry, bus.out_data, want);
                end
                got++;
            end
        end
        checks++;
        if (got != 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL sweep_count got %0d results (%0d pending) want 64", got, exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_directed_vectors();
        test_backpressure();
        test_bubbles();
        test_reset_mid_stream();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
